// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants for the data-memory arbiter
package dmem_arb_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;

   // FSM state encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   // requester identifiers
   localparam logic PORT_P = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/dmem_arb_rr_pick2.sv
// rtl/dmem_arb_rr_pick2.sv - combinational two-way round-robin / fixed-priority picker
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic req_p,
   input  logic req_d,
   input  logic last_grant,
   input  logic fixed_prio,
   output logic grant_valid,
   output logic grant_id
);

   // tie goes to P in fixed mode, otherwise to whichever port was not served last
   always_comb begin
      grant_valid = req_p | req_d;
      grant_id    = PORT_P;
      if (req_p && req_d) begin
         grant_id = fixed_prio ? PORT_P : ~last_grant;
      end else if (req_d) begin
         grant_id = PORT_D;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - serialises processor and debug accesses onto one dmem port
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH      = 4096,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_ack,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_err,
   output logic              p_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] address_dmem,
   output logic [DATA_W-1:0] data_dmem,
   output logic              wren,
   input  logic [DATA_W-1:0] q_dmem
);

   // one extra bit so DEPTH == 2**ADDR_W is representable
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              oor_q, oor_d;
   logic              p_ack_q, p_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              p_err_q, p_err_d;
   logic              d_err_q, d_err_d;
   logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic              p_elig, d_elig;
   logic              grant_valid, grant_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] resp_data;

   // a port whose ack is high this cycle is masked so a requester dropping req on ack is not re-served
   assign p_elig = p_req & ~p_ack_q;
   assign d_elig = d_req & ~d_ack_q;

   rr_pick2 u_pick (
      .req_p       (p_elig),
      .req_d       (d_elig),
      .last_grant  (last_grant_q),
      .fixed_prio  (FIXED_PRIO),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // state and datapath registers; reset drops any in-flight access without an ack
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= PORT_D;
         owner_q      <= PORT_P;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         oor_q        <= 1'b0;
         p_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         p_err_q      <= 1'b0;
         d_err_q      <= 1'b0;
         p_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         oor_q        <= oor_d;
         p_ack_q      <= p_ack_d;
         d_ack_q      <= d_ack_d;
         p_err_q      <= p_err_d;
         d_err_q      <= d_err_d;
         p_rdata_q    <= p_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   // next-state: IDLE waits for a grant, then a fixed ISSUE -> RESP -> IDLE walk
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_valid) state_d = S_ISSUE;
         S_ISSUE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // request latching on grant and response capture on the RESP -> IDLE edge
   always_comb begin
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      oor_d        = oor_q;
      p_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      p_err_d      = p_err_q;
      d_err_d      = d_err_q;
      p_rdata_d    = p_rdata_q;
      d_rdata_d    = d_rdata_q;
      sel_addr     = (grant_id == PORT_D) ? d_addr : p_addr;
      resp_data    = (oor_q || we_q) ? '0 : q_dmem;

      if (state_q == S_IDLE && grant_valid) begin
         owner_d      = grant_id;
         last_grant_d = grant_id;
         we_d         = (grant_id == PORT_D) ? d_we : p_we;
         addr_d       = sel_addr;
         wdata_d      = (grant_id == PORT_D) ? d_wdata : p_wdata;
         oor_d        = ({1'b0, sel_addr} >= DEPTH_L);
      end

      if (state_q == S_RESP) begin
         if (owner_q == PORT_P) begin
            p_ack_d   = 1'b1;
            p_rdata_d = resp_data;
            p_err_d   = oor_q;
         end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data;
            d_err_d   = oor_q;
         end
      end
   end

   // memory-side outputs; wren is also gated by reset so it falls immediately
   always_comb begin
      address_dmem = addr_q;
      data_dmem    = wdata_q;
      wren         = (state_q == S_ISSUE) & we_q & ~oor_q & reset;
   end

   assign p_ack   = p_ack_q;
   assign d_ack   = d_ack_q;
   assign p_err   = p_err_q;
   assign d_err   = d_err_q;
   assign p_rdata = p_rdata_q;
   assign d_rdata = d_rdata_q;
   assign p_stall = p_req & ~p_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        p_req = 1'b0, p_we = 1'b0;
   logic [11:0] p_addr = '0;
   logic [31:0] p_wdata = '0;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [11:0] d_addr = '0;
   logic [31:0] d_wdata = '0;

   // instance A: round-robin, DEPTH=1024; instance B: fixed priority, full depth
   logic        p_ack_a, p_err_a, p_stall_a, d_ack_a, d_err_a, wren_a;
   logic [31:0] p_rdata_a, d_rdata_a, data_dmem_a, q_a;
   logic [11:0] address_dmem_a;
   logic        p_ack_b, p_err_b, p_stall_b, d_ack_b, d_err_b, wren_b;
   logic [31:0] p_rdata_b, d_rdata_b, data_dmem_b, q_b;
   logic [11:0] address_dmem_b;

   logic [31:0] mem_a [4096];
   logic [31:0] mem_b [4096];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .DEPTH(1024), .FIXED_PRIO(1'b0)) dut_a (
      .clock(clock), .reset(reset),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_ack(p_ack_a), .p_rdata(p_rdata_a), .p_err(p_err_a), .p_stall(p_stall_a),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack_a), .d_rdata(d_rdata_a), .d_err(d_err_a),
      .address_dmem(address_dmem_a), .data_dmem(data_dmem_a), .wren(wren_a), .q_dmem(q_a)
   );

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096), .FIXED_PRIO(1'b1)) dut_b (
      .clock(clock), .reset(reset),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_ack(p_ack_b), .p_rdata(p_rdata_b), .p_err(p_err_b), .p_stall(p_stall_b),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack_b), .d_rdata(d_rdata_b), .d_err(d_err_b),
      .address_dmem(address_dmem_b), .data_dmem(data_dmem_b), .wren(wren_b), .q_dmem(q_b)
   );

   // synchronous single-port RAM models
   always @(posedge clock) begin
      if (wren_a) mem_a[address_dmem_a] <= data_dmem_a;
      q_a <= mem_a[address_dmem_a];
      if (wren_b) mem_b[address_dmem_b] <= data_dmem_b;
      q_b <= mem_b[address_dmem_b];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // one access on instance A's view: returns rdata/err, edges to ack, and wren cycles at addr
   task automatic access(input logic port, input logic we, input logic [11:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int wcnt);
      logic got;
      got = 1'b0;
      lat = 0;
      wcnt = 0;
      rd = '0;
      er = 1'b0;
      if (port) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
      end else begin
         p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wd;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         lat++;
         if (wren_a && address_dmem_a == addr) wcnt++;
         if (port ? d_ack_a : p_ack_a) begin
            got = 1'b1;
            rd = port ? d_rdata_a : p_rdata_a;
            er = port ? d_err_a : p_err_a;
         end
      end
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
      p_req = 1'b0;
      d_req = 1'b0;
      tick();
      chk("ack_width", {31'd0, port ? d_ack_a : p_ack_a}, 32'd0);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, wcnt;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      mem_a[0] = 32'h0000_00A5;
      mem_b[0] = 32'h0000_00A5;

      // reset held with P requesting: nothing may be acked or written
      p_req = 1'b1; p_we = 1'b0; p_addr = 12'd0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_p_ack", {31'd0, p_ack_a}, 32'd0);
         chk("rst_d_ack", {31'd0, d_ack_a}, 32'd0);
         chk("rst_p_err", {31'd0, p_err_a}, 32'd0);
         chk("rst_p_rdata", p_rdata_a, 32'd0);
         chk("rst_wren", {30'd0, wren_a, wren_b}, 32'd0);
      end
      reset = 1'b1;
      access(1'b0, 1'b0, 12'd0, 32'd0, rd, er, lat, wcnt);
      chk("rst_first_lat", lat, 32'd3);
      chk("rst_first_rdata", rd, 32'h0000_00A5);

      // P write then read back
      access(1'b0, 1'b1, 12'd5, 32'h0000_FFFF, rd, er, lat, wcnt);
      chk("wr_lat", lat, 32'd3);
      chk("wr_wren_cycles", wcnt, 32'd1);
      chk("wr_err", {31'd0, er}, 32'd0);
      chk("wr_rdata", rd, 32'd0);
      access(1'b0, 1'b0, 12'd5, 32'd0, rd, er, lat, wcnt);
      chk("rd_lat", lat, 32'd3);
      chk("rd_wren_cycles", wcnt, 32'd0);
      chk("rd_rdata", rd, 32'h0000_FFFF);
      chk("rd_err", {31'd0, er}, 32'd0);

      // preload, ending with a D grant so the next tie goes to P
      access(1'b0, 1'b1, 12'd1, 32'd1, rd, er, lat, wcnt);
      access(1'b1, 1'b1, 12'd2, 32'd2, rd, er, lat, wcnt);
      chk("d_wr_lat", lat, 32'd3);

      // both ports hold requests: acks alternate P,D,P,D three cycles apart
      p_req = 1'b1; p_we = 1'b0; p_addr = 12'd1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'd2;
      for (int t = 1; t <= 12; t++) begin
         tick();
         chk("alt_p_ack_a", {31'd0, p_ack_a}, {31'd0, (t % 6) == 3});
         chk("alt_d_ack_a", {31'd0, d_ack_a}, {31'd0, (t % 6) == 0});
         chk("alt_p_ack_b", {31'd0, p_ack_b}, {31'd0, (t % 6) == 3});
         chk("alt_d_ack_b", {31'd0, d_ack_b}, {31'd0, (t % 6) == 0});
         chk("alt_p_stall", {31'd0, p_stall_a}, {31'd0, (t % 6) != 3});
         if ((t % 6) == 3) chk("alt_p_rdata", p_rdata_a, 32'd1);
         if ((t % 6) == 0) chk("alt_d_rdata", d_rdata_b, 32'd2);
      end
      p_req = 1'b0;
      d_req = 1'b0;
      tick();
      chk("alt_idle_acks", {28'd0, p_ack_a, d_ack_a, p_ack_b, d_ack_b}, 32'd0);

      // tie after a P grant: round-robin serves D, fixed priority serves P
      access(1'b0, 1'b0, 12'd1, 32'd0, rd, er, lat, wcnt);
      p_req = 1'b1; p_addr = 12'd1;
      d_req = 1'b1; d_addr = 12'd2;
      tick();
      tick();
      tick();
      chk("tie_rr_acks", {30'd0, p_ack_a, d_ack_a}, 32'd1);
      chk("tie_fix_acks", {30'd0, p_ack_b, d_ack_b}, 32'd2);
      chk("tie_rr_d_rdata", d_rdata_a, 32'd2);
      chk("tie_fix_p_rdata", p_rdata_b, 32'd1);
      p_req = 1'b0;
      d_req = 1'b0;
      tick();
      tick();

      // out-of-range on instance A (DEPTH=1024)
      access(1'b1, 1'b1, 12'd2000, 32'hDEAD_BEEF, rd, er, lat, wcnt);
      chk("oor_wr_lat", lat, 32'd3);
      chk("oor_wr_wren", wcnt, 32'd0);
      chk("oor_wr_err", {31'd0, er}, 32'd1);
      chk("oor_wr_rdata", rd, 32'd0);
      access(1'b1, 1'b0, 12'd2000, 32'd0, rd, er, lat, wcnt);
      chk("oor_rd_err", {31'd0, er}, 32'd1);
      chk("oor_rd_rdata", rd, 32'd0);

      // reset during ISSUE of a P write: wren drops at once, no ack, memory untouched
      p_req = 1'b1; p_we = 1'b1; p_addr = 12'd5; p_wdata = 32'h1234_5678;
      tick();
      chk("mid_wren_before", {31'd0, wren_a}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_wren_gated", {31'd0, wren_a}, 32'd0);
      tick();
      p_req = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mid_no_ack", {31'd0, p_ack_a}, 32'd0);
      end
      access(1'b0, 1'b0, 12'd5, 32'd0, rd, er, lat, wcnt);
      chk("mid_readback", rd, 32'h0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
